// File: rtl/tlb_refill_walker.sv
// TLB miss handler: fetches a PTE from a flat single-level page table and fills the TLB or reports a fault.
// Optional WALK_TIMEOUT_EN bounds the memory wait to TIMEOUT_CYCLES and reports expiry as a fault.
module tlb_refill_walker #(
  parameter int unsigned     VA_W           = 16,
  parameter int unsigned     PA_W           = 16,
  parameter int unsigned     PAGE_BITS      = 8,
  parameter int unsigned     ENTRIES        = 16,
  parameter logic [PA_W-1:0] PT_BASE        = 16'h8000,
  parameter int unsigned     TIMEOUT_CYCLES = 64,
  localparam int unsigned    VPN_W          = VA_W - PAGE_BITS,
  localparam int unsigned    PPN_W          = PA_W - PAGE_BITS,
  localparam int unsigned    IDX_W          = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_req,
  input  logic [VA_W-1:0]  miss_vaddr,
  output logic             miss_ack,
  output logic             fault,
  output logic             busy,
  output logic             mem_req,
  output logic [PA_W-1:0]  mem_addr,
  input  logic             mem_ready,
  input  logic [15:0]      mem_rdata,
  output logic             tlb_wr_en,
  output logic [IDX_W-1:0] tlb_wr_idx,
  output logic [VPN_W-1:0] tlb_wr_vpn,
  output logic [PPN_W-1:0] tlb_wr_ppn
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]       state, state_d;
  logic [VPN_W-1:0] vpn, vpn_d;
  logic [IDX_W-1:0] victim, victim_d;
  logic             miss_ack_d, fault_d, busy_d, mem_req_d, tlb_wr_en_d;
  logic [PA_W-1:0]  mem_addr_d;
  logic [IDX_W-1:0] tlb_wr_idx_d;
  logic [VPN_W-1:0] tlb_wr_vpn_d;
  logic [PPN_W-1:0] tlb_wr_ppn_d;

`ifdef WALK_TIMEOUT_EN
  logic [7:0] wait_cnt, wait_cnt_d;
`endif

  // PTE attribute bits and the page offset carry no meaning for the walk
  logic unused_bits;
  assign unused_bits = ^{mem_rdata[14:PPN_W], miss_vaddr[PAGE_BITS-1:0]};

  // Next-state and next-output decode; every output is registered from these
  always_comb begin
    state_d      = state;
    vpn_d        = vpn;
    victim_d     = victim;
    miss_ack_d   = 1'b0;
    fault_d      = 1'b0;
    mem_req_d    = 1'b0;
    tlb_wr_en_d  = 1'b0;
    mem_addr_d   = mem_addr;
    tlb_wr_idx_d = tlb_wr_idx;
    tlb_wr_vpn_d = tlb_wr_vpn;
    tlb_wr_ppn_d = tlb_wr_ppn;
`ifdef WALK_TIMEOUT_EN
    wait_cnt_d   = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (miss_req) begin
          vpn_d      = miss_vaddr[VA_W-1:PAGE_BITS];
          mem_addr_d = PT_BASE + PA_W'(miss_vaddr[VA_W-1:PAGE_BITS]);
          mem_req_d  = 1'b1;
          state_d    = S_FETCH;
`ifdef WALK_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
        end
      end
      S_FETCH: begin
        mem_req_d = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_rdata[15]) begin
            state_d      = S_FILL;
            tlb_wr_en_d  = 1'b1;
            tlb_wr_idx_d = victim;
            tlb_wr_vpn_d = vpn;
            tlb_wr_ppn_d = mem_rdata[PPN_W-1:0];
          end else begin
            state_d    = S_ACK;
            miss_ack_d = 1'b1;
            fault_d    = 1'b1;
          end
        end
`ifdef WALK_TIMEOUT_EN
        else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d  = 1'b0;
          state_d    = S_ACK;
          miss_ack_d = 1'b1;
          fault_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 8'd1;
        end
`endif
      end
      S_FILL: begin
        victim_d   = victim + IDX_W'(1);
        state_d    = S_ACK;
        miss_ack_d = 1'b1;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vpn        <= '0;
      victim     <= '0;
      miss_ack   <= 1'b0;
      fault      <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      tlb_wr_en  <= 1'b0;
      tlb_wr_idx <= '0;
      tlb_wr_vpn <= '0;
      tlb_wr_ppn <= '0;
`ifdef WALK_TIMEOUT_EN
      wait_cnt   <= 8'd0;
`endif
    end else begin
      state      <= state_d;
      vpn        <= vpn_d;
      victim     <= victim_d;
      miss_ack   <= miss_ack_d;
      fault      <= fault_d;
      busy       <= busy_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      tlb_wr_en  <= tlb_wr_en_d;
      tlb_wr_idx <= tlb_wr_idx_d;
      tlb_wr_vpn <= tlb_wr_vpn_d;
      tlb_wr_ppn <= tlb_wr_ppn_d;
`ifdef WALK_TIMEOUT_EN
      wait_cnt   <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Scoreboard bench for tlb_refill_walker: directed walks push expected fills/acks, a monitor pops and compares.
module tb_tlb_refill_walker;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] vpn;
    logic [7:0] ppn;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [15:0] miss_vaddr;
  logic        miss_ack;
  logic        fault;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        tlb_wr_en;
  logic [3:0]  tlb_wr_idx;
  logic [7:0]  tlb_wr_vpn;
  logic [7:0]  tlb_wr_ppn;

  wr_t  wr_q[$];
  logic ack_q[$];
  wr_t  mon_w;
  logic mon_f;
  logic [3:0] exp_idx;
  int n_checks = 0;
  int n_fail   = 0;

  tlb_refill_walker dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_vaddr (miss_vaddr),
    .miss_ack   (miss_ack),
    .fault      (fault),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .tlb_wr_en  (tlb_wr_en),
    .tlb_wr_idx (tlb_wr_idx),
    .tlb_wr_vpn (tlb_wr_vpn),
    .tlb_wr_ppn (tlb_wr_ppn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write strobe and ack against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (tlb_wr_en) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wr: idx=%0h vpn=%0h ppn=%0h with no write expected", tlb_wr_idx, tlb_wr_vpn, tlb_wr_ppn);
        end else begin
          mon_w = wr_q.pop_front();
          check("wr_idx", 32'(tlb_wr_idx), 32'(mon_w.idx));
          check("wr_vpn", 32'(tlb_wr_vpn), 32'(mon_w.vpn));
          check("wr_ppn", 32'(tlb_wr_ppn), 32'(mon_w.ppn));
        end
      end
      if (miss_ack) begin
        if (ack_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: fault=%0b with no ack expected", fault);
        end else begin
          mon_f = ack_q.pop_front();
          check("ack_fault", 32'(fault), 32'(mon_f));
        end
      end
      if (tlb_wr_en || miss_ack)
        check("wr_ack_overlap", 32'(tlb_wr_en & miss_ack), 32'd0);
      if (mem_req)
        check("mem_req_busy", 32'(busy), 32'd1);
    end
  end

  // One complete walk; waits = cycles mem_ready is held low after mem_req rises
  task automatic walk(input logic [15:0] va, input logic [15:0] pte, input int waits);
    logic [15:0] exp_addr;
    logic        seen;
    exp_addr = 16'h8000 + {8'h00, va[15:8]};
    if (pte[15]) begin
      wr_q.push_back(wr_t'{idx: exp_idx, vpn: va[15:8], ppn: pte[7:0]});
      exp_idx = exp_idx + 4'd1;
    end
    ack_q.push_back(!pte[15]);
    @(posedge clk); #1;
    miss_req   = 1'b1;
    miss_vaddr = va;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    check("mem_req_rise", 32'(seen), 32'd1);
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    miss_vaddr = ~va;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("wait_mem_req", 32'(mem_req), 32'd1);
      check("wait_mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("wait_busy", 32'(busy), 32'd1);
    end
    mem_ready = 1'b1;
    mem_rdata = pte;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    @(negedge clk);
    check("mem_req_drop", 32'(mem_req), 32'd0);
    seen = miss_ack;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = miss_ack;
    end
    check("ack_seen", 32'(seen), 32'd1);
    miss_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_miss_ack"}, 32'(miss_ack), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_tlb_wr_en"}, 32'(tlb_wr_en), 32'd0);
    check({tag, "_tlb_wr_idx"}, 32'(tlb_wr_idx), 32'd0);
    check({tag, "_tlb_wr_vpn"}, 32'(tlb_wr_vpn), 32'd0);
    check({tag, "_tlb_wr_ppn"}, 32'(tlb_wr_ppn), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    int   cnt;
    rst        = 1'b1;
    miss_req   = 1'b0;
    miss_vaddr = 16'h0000;
    mem_ready  = 1'b0;
    mem_rdata  = 16'h0000;
    exp_idx    = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fault first: must not consume a victim slot
    walk(16'h05FF, 16'h0037, 0);
    walk(16'h12A4, 16'h8037, 0);

    // Back-to-back fills across the victim wrap; bit14 set to show it is ignored
    for (int i = 0; i < 17; i++)
      walk({8'(32'h20 + i * 3), 8'(i)}, {8'hC0, 8'(i * 5 + 1)}, 0);

    walk(16'hFF00, 16'h80AB, 2);
    walk(16'h4321, 16'h8055, 5);

    // Reset in the middle of FETCH; a late mem_ready must be ignored
    @(posedge clk); #1;
    miss_req   = 1'b1;
    miss_vaddr = 16'h3344;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    check("rst_walk_mem_req", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst      = 1'b1;
    miss_req = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h8099;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    exp_idx = 4'd0;
    walk(16'h7711, 16'h8042, 0);

`ifdef WALK_TIMEOUT_EN
    // Memory never answers: 64 waiting cycles then a faulting ack
    ack_q.push_back(1'b1);
    @(posedge clk); #1;
    miss_req   = 1'b1;
    miss_vaddr = 16'h5A00;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      seen = miss_ack;
    end
    check("timeout_ack", 32'(seen), 32'd1);
    check("timeout_wait_cycles", 32'(cnt), 32'd64);
    miss_req = 1'b0;
    @(posedge clk); #1;
    walk(16'h6600, 16'h8011, 0);
`else
    cnt = 0;
`endif

    repeat (4) @(negedge clk);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    check("final_busy", 32'(busy) + 32'(cnt) * 0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
